// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the 16-bit pipelined processor.
//
// Owns the PC, next-PC selection, the instruction-memory address and the
// IF/ID pipeline register feeding decode. A redirect kills the instruction
// fetched in the same cycle, so it costs exactly one bubble. A stall freezes
// the PC and IF/ID. Two saturating counters track delivered instructions and
// bubble/held cycles.
//
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   stall             hold PC and IF/ID (pc_src ignored while high)
//   pc_src[1:0]       00 PC+1, 01 branch_target, 10 jump_target, 11 return_addr
//   branch_target     I-type target from decode
//   jump_target       J-type target from decode
//   return_addr       return address from decode
//   inst_mem_addr     instruction-memory address (== PC)
//   inst_mem_data     combinational instruction word at inst_mem_addr
//   inst_ID           registered instruction for decode
//   PC_ID             registered address of inst_ID plus one
//   valid_ID          1 = real instruction, 0 = bubble
//   fetch_count       valid instructions delivered (saturating)
//   bubble_count      bubble-injected or held cycles (saturating)
// ----------------------------------------------------------------------------
module if_stage #(
    parameter int              WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] NOP_INST = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [1:0]       pc_src,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] return_addr,
    output logic [WIDTH-1:0] inst_mem_addr,
    input  logic [WIDTH-1:0] inst_mem_data,
    output logic [WIDTH-1:0] inst_ID,
    output logic [WIDTH-1:0] PC_ID,
    output logic             valid_ID,
    output logic [15:0]      fetch_count,
    output logic [15:0]      bubble_count
);

    localparam logic [1:0] SRC_SEQ = 2'b00;
    localparam logic [1:0] SRC_BR  = 2'b01;
    localparam logic [1:0] SRC_JMP = 2'b10;

    // IF/ID occupancy state: BUBBLE means inst_ID is an injected NOP.
    localparam logic [0:0] ST_BUBBLE = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] inst_q, inst_d;
    logic [WIDTH-1:0] pcid_q, pcid_d;
    logic [0:0]       state_q, state_d;
    logic [15:0]      fetch_cnt_q, fetch_cnt_d;
    logic [15:0]      bubble_cnt_q, bubble_cnt_d;

    logic [WIDTH-1:0] pc_plus1;
    logic [WIDTH-1:0] redirect_pc;
    logic             fetch_inc;
    logic             bubble_inc;

    // Wraps naturally at the top of the address space.
    assign pc_plus1 = pc_q + WIDTH'(1);

    always_comb begin
        unique case (pc_src)
            SRC_BR:  redirect_pc = branch_target;
            SRC_JMP: redirect_pc = jump_target;
            default: redirect_pc = return_addr;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        inst_d     = inst_q;
        pcid_d     = pcid_q;
        state_d    = state_q;
        fetch_inc  = 1'b0;
        bubble_inc = 1'b0;
        if (stall) begin
            // Everything holds; any redirect request is dropped and must be
            // re-presented by the controller once the stall clears.
            bubble_inc = 1'b1;
        end else if (pc_src != SRC_SEQ) begin
            // The word fetched this cycle is on the wrong path: kill it.
            pc_d       = redirect_pc;
            inst_d     = NOP_INST;
            pcid_d     = pc_plus1;
            state_d    = ST_BUBBLE;
            bubble_inc = 1'b1;
        end else begin
            pc_d      = pc_plus1;
            inst_d    = inst_mem_data;
            pcid_d    = pc_plus1;
            state_d   = ST_RUN;
            fetch_inc = 1'b1;
        end
    end

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (fetch_inc && fetch_cnt_q != CNT_MAX)
            fetch_cnt_d = fetch_cnt_q + 16'd1;
        if (bubble_inc && bubble_cnt_q != CNT_MAX)
            bubble_cnt_d = bubble_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            pcid_q       <= '0;
            state_q      <= ST_BUBBLE;
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            pcid_q       <= pcid_d;
            state_q      <= state_d;
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign inst_mem_addr = pc_q;
    assign inst_ID       = inst_q;
    assign PC_ID         = pcid_q;
    assign valid_ID      = (state_q == ST_RUN);
    assign fetch_count   = fetch_cnt_q;
    assign bubble_count  = bubble_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage -- directed testbench for if_stage. Instruction memory returns
// 16'h1000 + addr. Inputs change after the rising edge; outputs are sampled
// 1 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [1:0]  pc_src;
    logic [15:0] branch_target;
    logic [15:0] jump_target;
    logic [15:0] return_addr;
    logic [15:0] inst_mem_addr;
    logic [15:0] inst_mem_data;
    logic [15:0] inst_ID;
    logic [15:0] PC_ID;
    logic        valid_ID;
    logic [15:0] fetch_count;
    logic [15:0] bubble_count;

    int errors = 0;
    int checks = 0;

    if_stage #(.WIDTH(16), .RESET_PC(16'h0000), .NOP_INST(16'h0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .pc_src       (pc_src),
        .branch_target(branch_target),
        .jump_target  (jump_target),
        .return_addr  (return_addr),
        .inst_mem_addr(inst_mem_addr),
        .inst_mem_data(inst_mem_data),
        .inst_ID      (inst_ID),
        .PC_ID        (PC_ID),
        .valid_ID     (valid_ID),
        .fetch_count  (fetch_count),
        .bubble_count (bubble_count)
    );

    assign inst_mem_data = 16'h1000 + inst_mem_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [15:0] pc, input logic [15:0] inst,
                           input logic [15:0] pcid, input logic vld,
                           input logic [15:0] fc, input logic [15:0] bc);
        chk({tag, ".pc"},    inst_mem_addr, pc);
        chk({tag, ".inst"},  inst_ID,       inst);
        chk({tag, ".pcid"},  PC_ID,         pcid);
        chk({tag, ".valid"}, {15'd0, valid_ID}, {15'd0, vld});
        chk({tag, ".fcnt"},  fetch_count,   fc);
        chk({tag, ".bcnt"},  bubble_count,  bc);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; pc_src = 2'b00;
        branch_target = '0; jump_target = '0; return_addr = '0;
        #3;
        chk_all("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0, 16'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch from reset
        step(); step(); step();
        chk_all("seq3", 16'h0003, 16'h1002, 16'h0003, 1'b1, 16'd3, 16'd0);
        step(); step();
        chk_all("seq5", 16'h0005, 16'h1004, 16'h0005, 1'b1, 16'd5, 16'd0);

        // Branch at PC = 5
        pc_src = 2'b01; branch_target = 16'h0020;
        step();
        chk_all("br", 16'h0020, 16'h0000, 16'h0006, 1'b0, 16'd5, 16'd1);
        pc_src = 2'b00;
        step();
        chk_all("br_tgt", 16'h0021, 16'h1020, 16'h0021, 1'b1, 16'd6, 16'd1);

        // Return to 6, fetch once to reach PC = 7 with a valid IF/ID
        pc_src = 2'b11; return_addr = 16'h0006;
        step();
        chk_all("ret6", 16'h0006, 16'h0000, 16'h0022, 1'b0, 16'd6, 16'd2);
        pc_src = 2'b00;
        step();
        chk_all("seq7", 16'h0007, 16'h1006, 16'h0007, 1'b1, 16'd7, 16'd2);

        // Stall two cycles with a pending jump: jump ignored, state held
        stall = 1'b1; pc_src = 2'b10; jump_target = 16'h4ABC;
        step();
        chk_all("stall1", 16'h0007, 16'h1006, 16'h0007, 1'b1, 16'd7, 16'd3);
        step();
        chk_all("stall2", 16'h0007, 16'h1006, 16'h0007, 1'b1, 16'd7, 16'd4);
        stall = 1'b0;
        step();
        chk_all("jmp", 16'h4ABC, 16'h0000, 16'h0008, 1'b0, 16'd7, 16'd5);

        // Back-to-back redirects, the second landing on 0xFFFF
        pc_src = 2'b01; branch_target = 16'h0030;
        step();
        chk_all("b2b1", 16'h0030, 16'h0000, 16'h4ABD, 1'b0, 16'd7, 16'd6);
        pc_src = 2'b11; return_addr = 16'hFFFF;
        step();
        chk_all("b2b2", 16'hFFFF, 16'h0000, 16'h0031, 1'b0, 16'd7, 16'd7);

        // Fetch at 0xFFFF: PC and PC_ID wrap to 0
        pc_src = 2'b00;
        step();
        chk_all("wrap", 16'h0000, 16'h0FFF, 16'h0000, 1'b1, 16'd8, 16'd7);
        step();
        chk_all("wrap1", 16'h0001, 16'h1000, 16'h0001, 1'b1, 16'd9, 16'd7);

        // Asynchronous reset between edges during a redirect
        pc_src = 2'b01; branch_target = 16'h0055;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("areset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0, 16'd0);
        step();
        chk_all("areset_hold", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        pc_src = 2'b00;
        rst_n = 1'b1;

        // Fetch counter saturation: 65534 fetches reach 0xFFFE, then 3 more
        for (int i = 0; i < 65534; i++) step();
        chk("sat_pre.fcnt", fetch_count, 16'hFFFE);
        chk("sat_pre.pc",   inst_mem_addr, 16'hFFFE);
        step(); step(); step();
        chk("sat.fcnt", fetch_count,   16'hFFFF);
        chk("sat.pc",   inst_mem_addr, 16'h0001);
        chk("sat.inst", inst_ID,       16'h1000);
        chk("sat.bcnt", bubble_count,  16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 16-bit pipelined processor; sits directly upstream of the decode stage.
- Owns the PC register, next-PC selection (sequential, I-type branch, J-type jump, return), the instruction-memory address, and the IF/ID pipeline register that supplies decode with its instruction and PC.
- Also implements stall, flush and bubble insertion, plus two saturating performance counters.

Parameters:
- WIDTH, 16, datapath, PC and instruction width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INST, 16'h0000, instruction word injected as a bubble.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hazard-unit stall; holds PC and IF/ID.
- pc_src  input  2  next-PC select: 00 = PC+1, 01 = branch_target, 10 = jump_target, 11 = return_addr.
- branch_target  input  16  I-type target computed in decode.
- jump_target  input  16  J-type target, {PC_ID[15:12], imm12}.
- return_addr  input  16  return address (register value) from decode.
- inst_mem_addr  output  16  instruction-memory address; combinationally equal to PC.
- inst_mem_data  input  16  instruction word at inst_mem_addr; combinational read.
- inst_ID  output  16  registered instruction for decode.
- PC_ID  output  16  registered address of that instruction plus 1.
- valid_ID  output  1  1 = inst_ID is a real instruction, 0 = bubble.
- fetch_count  output  16  count of valid instructions delivered to IF/ID.
- bubble_count  output  16  count of cycles in which a bubble was injected or IF/ID was held.

Behaviour:
- Reset (rst_n low, asynchronous): PC = RESET_PC, inst_ID = NOP_INST, PC_ID = 16'h0000, valid_ID = 0, fetch_count = 0, bubble_count = 0. Reset asserted mid-operation discards all in-flight state immediately.
- After release, the first valid instruction appears in IF/ID on the first rising edge.
- pc_plus1 = PC + 1, modulo 2^16; 16'hFFFF wraps to 16'h0000. Word-addressed, so decode's PC-relative math uses PC_ID - 1 as the instruction address.
- Per-cycle priority, evaluated at each rising edge while rst_n is high:
  - (1) stall = 1: PC, inst_ID, PC_ID and valid_ID all hold. pc_src is ignored; the controller must re-present the redirect after the stall clears. bubble_count increments.
  - (2) stall = 0, pc_src != 00 (redirect): PC <= the selected target. IF/ID <= {NOP_INST, PC_ID = pc_plus1, valid_ID = 0}; the wrong-path instruction is killed. bubble_count increments; fetch_count does not.
  - (3) stall = 0, pc_src = 00: PC <= pc_plus1. IF/ID <= {inst_mem_data, pc_plus1, 1}. fetch_count increments.
- Redirect penalty is exactly one bubble cycle. The target instruction is in IF/ID one edge after the redirect edge.
- Counters saturate at 16'hFFFF and never wrap.
- State machine on valid_ID: RUN (valid_ID = 1) and BUBBLE (valid_ID = 0).
  - RESET -> BUBBLE.
  - Any redirect -> BUBBLE.
  - Sequential fetch -> RUN.
  - Stall -> stay in the current state.
- Redirect whose target equals the current PC: legal; treated as a normal redirect with one bubble.
- Back-to-back redirects on consecutive cycles: each one kills the fetch and updates PC; valid_ID stays 0.
- inst_mem_addr changes only after a PC update. With no redirect it is glitch-free relative to stall.

Test Plan:
- Reset, then release with pc_src = 00 and memory returning 16'h1000 + addr -> after 3 edges, PC = 3, inst_ID = 16'h1002, PC_ID = 3, valid_ID = 1, fetch_count = 3, bubble_count = 0.
- At PC = 5, assert pc_src = 01 with branch_target = 16'h0020 for one cycle -> next edge: PC = 16'h0020, valid_ID = 0, inst_ID = NOP_INST. Following edge: inst_ID = mem[16'h0020], PC_ID = 16'h0021, valid_ID = 1.
- Hold stall = 1 for 2 cycles at PC = 7 while pc_src = 10 -> PC stays 7, IF/ID unchanged, bubble_count += 2, jump ignored. Release with pc_src = 10 and jump_target = 16'h4ABC -> PC = 16'h4ABC.
- Preload PC = 16'hFFFF via return_addr (pc_src = 11), then run sequentially -> PC_ID = 16'h0000 for the word at 16'hFFFF, and PC wraps to 16'h0000.
- Drop rst_n asynchronously between edges during a redirect -> all outputs return to reset values immediately, with no clock edge required.
- Force fetch_count to 16'hFFFE (run 65534 valid fetches, or force in the bench), then run 3 more sequential cycles -> fetch_count holds at 16'hFFFF.
